sweep_ctrl: RTL
===============

# sweep_ctrl

Frequency-sweep scheduler driving the 16-bit `frq` input of the sine generator. It steps the commanded frequency from a start value to a stop value in programmable increments. Each frequency is held for a programmable dwell time in milliseconds. It runs either one sweep or repeats until aborted. The block sits between the host/UART register bank and the sine generator, and gives the Sigma-Delta bench automated frequency-response scans.

## Interface
Parameters:
- `C_CLK_FRQ`, 100_000_000, clock frequency in Hz; `C_MS_CYCLES = C_CLK_FRQ / 1000` cycles per dwell tick (must be ≥ 2).

Ports:
- `clk`  in  1  master clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  start request; sampled only in IDLE.
- `abort`  in  1  stop request; honoured in any non-IDLE state.
- `loop`  in  1  0 = single sweep, 1 = repeat sweeps until abort; latched at start.
- `frq_start`  in  16  first frequency [Hz]; latched at start.
- `frq_stop`  in  16  last frequency [Hz]; latched at start.
- `frq_step`  in  16  increment magnitude [Hz]; latched at start.
- `dwell`  in  16  hold time per frequency [ms]; latched at start; 0 is treated as 1.
- `frq`  out  16  commanded frequency to the sine generator; 0 when idle.
- `step_stb`  out  1  one-cycle pulse in the first cycle a new `frq` value is presented.
- `busy`  out  1  high from the first sweep cycle until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion of a single sweep.

## Operation
- States: IDLE, DWELL, STEP, DONE.
- IDLE: `frq`=0, `busy`=0. On `start`=1 and `abort`=0:
  - latch all configuration inputs;
  - load `frq`←`frq_start`, pulse `step_stb`, clear the dwell counters;
  - go to DWELL.
  - If `start` and `abort` are both high, `abort` wins and the block stays in IDLE.
- DWELL: a ms-prescaler counts 0..C_MS_CYCLES−1, and a ms counter counts dwell ticks. When the last cycle of the last tick is reached, go to STEP.
- STEP (one cycle, `frq` unchanged). Direction is up if `frq_start` ≤ `frq_stop`, otherwise down.
  - If current `frq` == `frq_stop` or `frq_step` == 0, the sweep is complete:
    - if `loop`=1: `frq`←`frq_start`, pulse `step_stb`, go to DWELL;
    - otherwise go to DONE.
  - Else compute next in 17-bit arithmetic:
    - up: `frq`+`frq_step`, clamped to `frq_stop` if greater;
    - down: `frq`−`frq_step`, clamped to `frq_stop` if less (borrow counts as less).
    - Load next into `frq`, pulse `step_stb`, clear the counters, go to DWELL.
- DONE (one cycle): `done`=1, `frq`←0, go to IDLE.
- Abort: in DWELL, STEP or DONE, `abort`=1 sends the block to IDLE on the next edge. `frq`←0, `busy`←0, no `done` pulse. Abort has priority over every other transition except `rst`.
- `start` while `busy`=1 is ignored. Configuration input changes during a sweep are ignored.
- `frq_start` == `frq_stop`: the block dwells once at that value, then completes (or reloads, if looping).

## Timing
- Reset: `rst` high at an edge forces IDLE, `frq`=0, `step_stb`=0, `busy`=0, `done`=0, and clears all counters and latches. This applies mid-sweep too, and takes effect at the same edge.
- Start latency: `start` high at edge N gives `frq`=`frq_start`, `step_stb`=1 and `busy`=1 after edge N.
- Dwell: each frequency, including the last, is presented for exactly max(`dwell`,1)·C_MS_CYCLES + 1 cycles. This is the dwell plus one STEP cycle.
- Single sweep of K frequencies: `busy` is high for K·(D·C_MS_CYCLES+1)+1 cycles, where D = max(`dwell`,1).
  - `done` is high in the last of these cycles, together with `frq`=0.
  - `busy` drops on the following edge.
- `step_stb` is never high on two consecutive cycles. `done` and `step_stb` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Use C_CLK_FRQ=10_000, so C_MS_CYCLES=10.
- Up sweep, clamped: start=1000, stop=1250, step=100, dwell=2, loop=0.
  - `frq` = 1000, 1100, 1200, 1250, each held 21 cycles.
  - 4 `step_stb` pulses; `done` 85 cycles after `start`; then `frq`=0.
- Down sweep: start=500, stop=200, step=150, dwell=0.
  - `frq` = 500, 350, 200, each held 11 cycles; then `done`.
- Loop and abort: start=100, stop=300, step=100, dwell=1, loop=1.
  - Sequence 100, 200, 300, 100, 200, ...
  - `abort` asserted mid-dwell of the second 200: next cycle `frq`=0, `busy`=0, no `done`.
- Degenerate cases:
  - step=0 with start=stop=777: single 777 dwell, then `done`.
  - start and abort asserted in the same cycle: stays IDLE, `frq`=0.
- Reset mid-sweep and ignored inputs:
  - `rst` pulsed during DWELL: all outputs 0 at that edge.
  - A subsequent `start` runs a full fresh sweep.
  - `start` pulses and configuration changes applied while `busy` do not alter the running sequence.

Source files
------------

// File: rtl/sweep_ctrl.sv
// ============================================================================
// Module   : sweep_ctrl
// Brief    : Frequency-sweep scheduler stepping the sine generator frequency
//            from a start to a stop value with a per-step millisecond dwell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sweep_ctrl #(
    parameter int C_CLK_FRQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        loop,
    input  logic [15:0] frq_start,
    input  logic [15:0] frq_stop,
    input  logic [15:0] frq_step,
    input  logic [15:0] dwell,
    output logic [15:0] frq,
    output logic        step_stb,
    output logic        busy,
    output logic        done
);

    localparam int                 C_MS_CYCLES = C_CLK_FRQ / 1000;
    localparam int                 C_PRE_W     = (C_MS_CYCLES > 2) ? $clog2(C_MS_CYCLES) : 1;
    localparam logic [C_PRE_W-1:0] C_PRE_LAST  = C_PRE_W'(C_MS_CYCLES - 1);
    localparam logic [C_PRE_W-1:0] C_PRE_ONE   = C_PRE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [15:0]        r_frq, w_frq;
    logic               r_stb, w_stb;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [C_PRE_W-1:0] r_pre, w_pre;
    logic [15:0]        r_ms, w_ms;

    logic               r_loop, r_up;
    logic [15:0]        r_fstart, r_fstop, r_fstep, r_dwell;

    logic               w_load;
    logic               w_last;
    logic [16:0]        w_sum, w_diff;
    logic [15:0]        w_next;

    assign w_load = (r_state == S_IDLE) && start && !abort;
    assign w_last = (r_frq == r_fstop) || (r_fstep == 16'd0);
    assign w_sum  = {1'b0, r_frq} + {1'b0, r_fstep};
    assign w_diff = {1'b0, r_frq} - {1'b0, r_fstep};

    // Clamp to the stop value; a borrow on the way down counts as undershoot.
    always_comb begin
        w_next = r_fstop;
        if (r_up) begin
            if (w_sum <= {1'b0, r_fstop})
                w_next = w_sum[15:0];
        end else begin
            if (!w_diff[16] && (w_diff[15:0] >= r_fstop))
                w_next = w_diff[15:0];
        end
    end

    always_comb begin
        w_state = r_state;
        w_frq   = r_frq;
        w_stb   = 1'b0;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pre   = r_pre;
        w_ms    = r_ms;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state = S_DWELL;
                    w_frq   = frq_start;
                    w_stb   = 1'b1;
                    w_busy  = 1'b1;
                    w_pre   = '0;
                    w_ms    = '0;
                end
            end
            S_DWELL: begin
                if (r_pre == C_PRE_LAST) begin
                    w_pre = '0;
                    if (r_ms == r_dwell - 16'd1)
                        w_state = S_STEP;
                    else
                        w_ms = r_ms + 16'd1;
                end else begin
                    w_pre = r_pre + C_PRE_ONE;
                end
            end
            S_STEP: begin
                w_pre = '0;
                w_ms  = '0;
                if (w_last && !r_loop) begin
                    w_state = S_DONE;
                    w_frq   = 16'd0;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_DWELL;
                    w_frq   = w_last ? r_fstart : w_next;
                    w_stb   = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_frq   = 16'd0;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_frq   = 16'd0;
                w_busy  = 1'b0;
            end
        endcase
        if ((r_state != S_IDLE) && abort) begin
            w_state = S_IDLE;
            w_frq   = 16'd0;
            w_stb   = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b0;
            w_pre   = '0;
            w_ms    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_frq   <= 16'd0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pre   <= '0;
            r_ms    <= 16'd0;
        end else begin
            r_state <= w_state;
            r_frq   <= w_frq;
            r_stb   <= w_stb;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pre   <= w_pre;
            r_ms    <= w_ms;
        end
    end

    // Configuration is captured only when a sweep is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop   <= 1'b0;
            r_up     <= 1'b1;
            r_fstart <= 16'd0;
            r_fstop  <= 16'd0;
            r_fstep  <= 16'd0;
            r_dwell  <= 16'd1;
        end else if (w_load) begin
            r_loop   <= loop;
            r_up     <= (frq_start <= frq_stop);
            r_fstart <= frq_start;
            r_fstop  <= frq_stop;
            r_fstep  <= frq_step;
            r_dwell  <= (dwell == 16'd0) ? 16'd1 : dwell;
        end
    end

    assign frq      = r_frq;
    assign step_stb = r_stb;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire
